// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer
// Output stage behind the transposed FIR filter. It decimates the filter output,
// rounds it half toward +inf, narrows it to OUT_W bits and queues it in a
// show-ahead FIFO with a valid/ready interface.
// Build option: define FIR_QUANT_SAT_EN to clip out-of-range samples and report
// them on sat_sticky. Without it the samples wrap in two's complement and
// sat_sticky stays 0.
module fir_output_quantizer #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 16,
  parameter int SHIFT = 10,
  parameter int DEC   = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat_sticky,
  output logic [7:0]              drop_cnt,
  input  logic                    clear
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(2 ** (SHIFT - 1));

  // ---------------------------------------------------------------- decimation
  logic [DCW-1:0] dec_cnt;
  logic           kept;

  assign kept = in_valid && (dec_cnt == '0);

  // Phase counter advances on valid input only; phase 0 is the kept sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (in_valid) begin
      dec_cnt <= (dec_cnt == DCW'(DEC - 1)) ? '0 : dec_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic                   v1;
  logic signed [IN_W-1:0] s1_data;

  // Capture the kept sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= 1'b0;
      s1_data <= '0;
    end else begin
      v1 <= kept;
      if (kept) begin
        s1_data <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------- rounding
  // One guard bit on top keeps the +half addition from overflowing.
  logic signed [IN_W:0]    biased;
  logic signed [OUT_W-1:0] q_next;

  assign biased = $signed({s1_data[IN_W-1], s1_data}) + HALF;

`ifdef FIR_QUANT_SAT_EN
  localparam int R_W = IN_W + 1 - SHIFT;
  localparam logic signed [R_W-1:0] MAX_R = R_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [R_W-1:0] MIN_R = R_W'(-(2 ** (OUT_W - 1)));

  logic signed [R_W-1:0] r;
  logic                  sat_next;
  logic                  v2_sat;

  assign r = R_W'(biased >>> SHIFT);

  // Clip the rounded value to the OUT_W range and flag the clip.
  always_comb begin
    q_next   = r[OUT_W-1:0];
    sat_next = 1'b0;
    if (r > MAX_R) begin
      q_next   = {1'b0, {(OUT_W-1){1'b1}}};
      sat_next = 1'b1;
    end else if (r < MIN_R) begin
      q_next   = {1'b1, {(OUT_W-1){1'b0}}};
      sat_next = 1'b1;
    end
  end
`else
  // Plain truncation to OUT_W bits: out-of-range samples wrap.
  assign q_next = OUT_W'(biased >>> SHIFT);
`endif

  // ---------------------------------------------------------------- stage 2
  logic                    v2;
  logic signed [OUT_W-1:0] s2_data;

  // Register the quantized sample (and its clip flag when clipping is built in).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2      <= 1'b0;
      s2_data <= '0;
`ifdef FIR_QUANT_SAT_EN
      v2_sat  <= 1'b0;
`endif
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_data <= q_next;
`ifdef FIR_QUANT_SAT_EN
        v2_sat  <= sat_next;
`endif
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [DEPTH-1:0]        wr_sel;
  logic signed [OUT_W-1:0] last_head;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_valid && out_ready;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push  = v2 && (!full || pop);
  assign drop  = v2 && full && !pop;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push && (wr_ptr[AW-1:0] == AW'(gi));
    end
  endgenerate

  // Storage: write the addressed entry on an accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem[i] <= s2_data;
        end
      end
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Remember the current head so out_data holds steady once the FIFO drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_head <= '0;
    end else if (!empty) begin
      last_head <= mem[rd_ptr[AW-1:0]];
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? last_head : mem[rd_ptr[AW-1:0]];

  // ---------------------------------------------------------------- status
  // Count dropped samples, saturating at 255; an event concurrent with clear survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef FIR_QUANT_SAT_EN
  logic sat_event;

  // Clipped samples count whether they are stored or dropped.
  assign sat_event = v2 && v2_sat;

  // Sticky clip flag; a clip concurrent with clear survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_sticky <= 1'b0;
    end else if (clear) begin
      sat_sticky <= sat_event;
    end else if (sat_event) begin
      sat_sticky <= 1'b1;
    end
  end
`else
  assign sat_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Testbench for fir_output_quantizer: directed scenarios followed by random
// traffic, checked by a queue-based reference model and a negedge monitor.
module tb_fir_output_quantizer;

  localparam int IN_W  = 26;
  localparam int OUT_W = 16;
  localparam int SHIFT = 10;
  localparam int DEC   = 2;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [IN_W-1:0]  in_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    sat_sticky;
  logic [7:0]              drop_cnt;
  logic                    clear = 1'b0;

  fir_output_quantizer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEC(DEC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_sticky(sat_sticky), .drop_cnt(drop_cnt), .clear(clear)
  );

  always #5 clk = ~clk;

  int cmp_count = 0;
  int err_count = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    cmp_count++;
    if (act != exp) begin
      err_count++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference quantizer: floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clip or wrap.
  function automatic void quantize(input longint x, output longint q, output bit s);
    longint v;
    longint r;
    longint w;
    longint lim;
    lim = longint'(1) << (OUT_W - 1);
    v = x + (longint'(1) << (SHIFT - 1));
    if (v >= 0) r = v / (longint'(1) << SHIFT);
    else        r = -((-v + (longint'(1) << SHIFT) - 1) / (longint'(1) << SHIFT));
`ifdef FIR_QUANT_SAT_EN
    if (r > lim - 1)   begin q = lim - 1; s = 1'b1; end
    else if (r < -lim) begin q = -lim;    s = 1'b1; end
    else               begin q = r;       s = 1'b0; end
`else
    s = 1'b0;
    w = r & ((longint'(1) << OUT_W) - 1);
    if (w >= lim) w = w - 2 * lim;
    q = w;
`endif
  endfunction

  typedef struct {
    longint val;
    bit     sat;
    int     due;
  } pend_t;

  pend_t  pend[$];   // kept samples still travelling toward the FIFO
  longint sb[$];     // expected FIFO contents, head first
  int     m_dec = 0;
  int     m_cycle = 0;
  bit     m_sticky = 1'b0;
  int     m_drop = 0;

  // Reference model: a sample kept at edge n reaches the FIFO at edge n+2.
  always @(posedge clk or posedge reset) begin
    bit     ev_drop;
    bit     ev_sat;
    pend_t  p;
    longint q;
    bit     s;
    if (reset) begin
      pend.delete();
      sb.delete();
      m_dec    = 0;
      m_sticky = 1'b0;
      m_drop   = 0;
    end else begin
      ev_drop = 1'b0;
      ev_sat  = 1'b0;
      m_cycle++;
      while (pend.size() > 0 && pend[0].due == m_cycle) begin
        p = pend.pop_front();
        if (p.sat) ev_sat = 1'b1;
        // sb already reflects a pop at this edge (monitor pops on the prior negedge)
        if (sb.size() < DEPTH) sb.push_back(p.val);
        else ev_drop = 1'b1;
      end
      if (clear) begin
        m_sticky = ev_sat;
        m_drop   = ev_drop ? 1 : 0;
      end else begin
        if (ev_sat) m_sticky = 1'b1;
        if (ev_drop && m_drop < 255) m_drop++;
      end
      if (in_valid) begin
        if (m_dec == 0) begin
          quantize(longint'(in_data), q, s);
          pend.push_back('{val: q, sat: s, due: m_cycle + 2});
        end
        m_dec = (m_dec + 1) % DEC;
      end
    end
  end

  // Monitor: compare presented outputs mid-cycle and consume popped samples.
  always @(negedge clk) begin
    check("out_valid", longint'(out_valid), longint'(sb.size() > 0));
    check("drop_cnt", longint'(drop_cnt), longint'(m_drop));
    check("sat_sticky", longint'(sat_sticky), longint'(m_sticky));
    if (sb.size() > 0 && out_ready) begin
      check("out_data", longint'(out_data), sb[0]);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input longint d);
    in_valid = v;
    in_data  = d[IN_W-1:0];
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  longint round_vals[5] = '{512, 511, 1535, -512, -513};
  longint sat_vals[2]   = '{33554431, -33554432};
  longint dec_vals[4]   = '{1024, 2048, 3072, 4096};

  initial begin
    logic signed [IN_W-1:0] rnd;
    longint d;

    // Reset state
    tick();
    tick();
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_data", longint'(out_data), 0);
    check("reset sat_sticky", longint'(sat_sticky), 0);
    check("reset drop_cnt", longint'(drop_cnt), 0);
    reset = 1'b0;
    tick();

    // Rounding: each value is followed by a discarded decimation slot
    out_ready = 1'b1;
    foreach (round_vals[i]) begin
      drive(1'b1, round_vals[i]);
      drive(1'b1, 0);
    end
    idle(4);

    // Saturation extremes, then clear the sticky flag
    foreach (sat_vals[i]) begin
      drive(1'b1, sat_vals[i]);
      drive(1'b1, 0);
    end
    idle(4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("sat_sticky after clear", longint'(sat_sticky), 0);

    // Decimation by 2 on back-to-back samples
    foreach (dec_vals[i]) drive(1'b1, dec_vals[i]);
    idle(4);

    // Backpressure: six kept samples into a four-entry FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1024 * k);
      drive(1'b1, 0);
    end
    idle(4);
    check("backpressure out_valid", longint'(out_valid), 1);
    check("backpressure drop_cnt", longint'(drop_cnt), 2);
    out_ready = 1'b1;
    idle(6);
    check("drained out_valid", longint'(out_valid), 0);

    // Full FIFO with push and pop in the same cycle
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1024 * (k + 10));
      drive(1'b1, 0);
    end
    drive(1'b1, 1024 * 20);
    drive(1'b1, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("push+pop drop_cnt", longint'(drop_cnt), 2);
    out_ready = 1'b1;
    idle(6);

    // Reset mid-stream with the FIFO and pipeline loaded and decimation mid-phase
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1024 * (k + 30));
      drive(1'b1, 0);
    end
    drive(1'b1, 1024 * 40);
    reset = 1'b1;
    #1;
    check("midreset out_valid", longint'(out_valid), 0);
    check("midreset out_data", longint'(out_data), 0);
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 1024 * 50);
    drive(1'b1, 0);
    idle(4);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: begin rnd = IN_W'($urandom); d = longint'(rnd); end
        1: d = longint'($urandom_range(0, 8191)) - 4096;
        2: d = 33554431 - longint'($urandom_range(0, 1023));
        default: d = -33554432 + longint'($urandom_range(0, 1023));
      endcase
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 40) == 0);
      drive(($urandom_range(0, 3) != 0), d);
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    idle(10);
    check("final out_valid", longint'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/fir_output_quantizer.md
# fir_output_quantizer

Output stage directly downstream of the low-cost transposed FIR filter. Accepts the filter's 26-bit signed result, decimates by a fixed factor, rounds and (optionally) saturates to 16 bits, and buffers the samples in a small FIFO behind a valid/ready handshake. It lets a stalling consumer sit behind the filter's free-running one-sample-per-clock output without losing data silently.

## Interface
- IN_W, 26, input sample width (filter output width)
- OUT_W, 16, output sample width
- SHIFT, 10, LSBs dropped by rounding; IN_W+1-SHIFT ≥ OUT_W
- DEC, 2, decimation factor (≥1; 1 = no decimation)
- DEPTH, 4, FIFO entries, power of two ≥2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data valid this cycle (tie high behind the filter)
- in_data  in  IN_W  signed filter output
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- out_data  out  OUT_W  signed head-of-FIFO sample
- sat_sticky  out  1  a sample was clipped since last clear
- drop_cnt  out  8  samples dropped on FIFO full since last clear, saturates at 255
- clear  in  1  synchronous clear of sat_sticky and drop_cnt

## Operation
- Decimation: dec_cnt counts 0..DEC-1, advances only on in_valid, wraps. A sample is kept when in_valid && dec_cnt==0. The first valid sample after reset is kept.
- Stage 1: kept sample registered with valid bit v1.
- Stage 2 (round): r = (sext(in,IN_W+1) + 2^(SHIFT-1)) >>> SHIFT, width IN_W+1-SHIFT (17 by default). Round half toward +inf. Result registered with v2, together with its sat flag.
- Saturation: see Configuration.
- FIFO: pushed when v2=1; show-ahead, so out_data = head entry with no read latency. out_valid = !empty. Pop = out_valid && out_ready.
- Full: a push with FIFO full and no pop in the same cycle drops the new sample and increments drop_cnt. Full with simultaneous pop accepts the push, and occupancy stays at DEPTH.
- Empty: push accepted. out_valid rises the next cycle; no bypass.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.
- sat_sticky and drop_cnt: clear zeroes them. If an event coincides with clear, the event is recorded, giving sat_sticky=1 and drop_cnt=1.
- out_data when empty: holds the last head value. Consumers ignore it.

## Timing
- Reset values: out_valid=0, out_data=0, sat_sticky=0, drop_cnt=0. FIFO is empty, dec_cnt=0, and v1=v2=0.
- Reset mid-operation discards the pipeline and FIFO contents immediately. Decimation phase restarts at 0.
- Latency: a sample captured at edge E is written to the FIFO at edge E+2. out_valid is high after E+2 if the FIFO was empty.
- Throughput: one kept sample per clock is sustained when out_ready=1.
- out_ready is sampled at the rising edge. out_data/out_valid change only at edges.

## Configuration
- FIR_QUANT_SAT_EN defined:
  - r > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1.
  - r < -2^(OUT_W-1) → -2^(OUT_W-1).
  - The clip sets the stage-2 sat flag, which sets sat_sticky when pushed.
  - Clipped samples that are dropped still set sat_sticky.
- FIR_QUANT_SAT_EN undefined:
  - out = r[OUT_W-1:0], two's-complement wrap.
  - sat_sticky is tied to 0.

## Test plan
- Rounding (DEC=1, out_ready=1): in_data 512, 511, 1535, -512, -513 → out_data 1, 0, 1, 0, -1, each 2 edges after capture.
- Saturation: in_data 33554431 → 32767 and sat_sticky=1 with macro; -32768 with sat_sticky=0 without macro. in_data -33554432 → -32768 in both builds. Pulse clear → sat_sticky=0.
- Decimation (DEC=2): in_data 1024, 2048, 3072, 4096 on consecutive cycles → outputs 1, 3 only.
- Backpressure (DEC=1, out_ready=0): 6 samples 1024·k (k=1..6) → out_valid=1, 4 stored, drop_cnt=2. Then out_ready=1 → drains 1, 2, 3, 4 in order, then out_valid=0.
- Full with simultaneous push and pop: FIFO holds 4 entries, out_ready=1, one new sample → pop and push both occur, occupancy stays 4, drop_cnt unchanged.
- Reset mid-stream: assert reset with 3 entries queued and v1=v2=1 → out_valid=0 and out_data=0 immediately. After release, the first valid sample is kept regardless of the prior dec_cnt value.
